// File: rtl/mm_pkg.sv
// Shared types for the matrix accelerator compute side.
// Sequencer state, default index width and the MAC op bundle.
package mm_pkg;

  localparam int DEF_IDX_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } seq_state_t;

  typedef struct packed {
    logic [DEF_IDX_W-1:0] i;
    logic [DEF_IDX_W-1:0] j;
    logic [DEF_IDX_W-1:0] k;
    logic                 first;
    logic                 last;
  } mm_op_t;

  function automatic logic dim_ok(
    input logic [31:0] d,
    input int          w
  );
    logic [32:0] lim;
    lim = 33'd1 << w;
    return (d != 32'd0) && ({1'b0, d} <= lim);
  endfunction

endpackage

// File: rtl/idx_wrap_cnt.sv
// Index counter that wraps to zero after reaching max.
// wrap flags the increment that performs the wrap, for chaining.
module idx_wrap_cnt #(
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [IDX_W-1:0] max,
  output logic [IDX_W-1:0] q,
  output logic             wrap
);

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  assign wrap = inc && (q == max);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= wrap ? '0 : q + ONE;
    end
  end

endmodule

// File: rtl/mm_loop_sequencer.sv
// Walks i/j/k over M x N x K and issues one MAC op per triple,
// then waits for the datapath to drain before pulsing done.
module mm_loop_sequencer
  import mm_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      cfg_m,
  input  logic [31:0]      cfg_k,
  input  logic [31:0]      cfg_n,
  input  logic             start,
  output logic             done,
  output logic             busy,
  output logic             cfg_err,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [IDX_W-1:0] op_i,
  output logic [IDX_W-1:0] op_j,
  output logic [IDX_W-1:0] op_k,
  output logic             op_first,
  output logic             op_last,
  input  logic             dp_idle
);

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  seq_state_t       state;
  seq_state_t       state_nx;
  logic [IDX_W-1:0] max_m;
  logic [IDX_W-1:0] max_k;
  logic [IDX_W-1:0] max_n;
  logic             accept;
  logic             bad;
  logic             hs;
  logic             k_wrap;
  logic             j_wrap;
  logic             i_wrap;

  assign accept   = (state == IDLE) && start;
  assign bad      = !dim_ok(cfg_m, IDX_W) ||
                    !dim_ok(cfg_k, IDX_W) ||
                    !dim_ok(cfg_n, IDX_W);
  assign op_valid = (state == ISSUE);
  assign hs       = op_valid && op_ready;
  assign done     = (state == FINISH);
  assign busy     = (state != IDLE);

  idx_wrap_cnt #(.IDX_W(IDX_W)) u_k (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .inc  (hs),
    .max  (max_k),
    .q    (op_k),
    .wrap (k_wrap)
  );

  idx_wrap_cnt #(.IDX_W(IDX_W)) u_j (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .inc  (k_wrap),
    .max  (max_n),
    .q    (op_j),
    .wrap (j_wrap)
  );

  idx_wrap_cnt #(.IDX_W(IDX_W)) u_i (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .inc  (j_wrap),
    .max  (max_m),
    .q    (op_i),
    .wrap (i_wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = bad ? FINISH : ISSUE;
      ISSUE:   if (i_wrap) state_nx = DRAIN;
      DRAIN:   if (dp_idle) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // first/last track the k value the counter will hold next
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_m    <= '0;
      max_k    <= '0;
      max_n    <= '0;
      cfg_err  <= 1'b0;
      op_first <= 1'b0;
      op_last  <= 1'b0;
    end else if (accept) begin
      max_m    <= IDX_W'(cfg_m - 32'd1);
      max_k    <= IDX_W'(cfg_k - 32'd1);
      max_n    <= IDX_W'(cfg_n - 32'd1);
      cfg_err  <= bad;
      op_first <= !bad;
      op_last  <= !bad && (cfg_k == 32'd1);
    end else if (hs) begin
      if (i_wrap) begin
        op_first <= 1'b0;
        op_last  <= 1'b0;
      end else begin
        op_first <= k_wrap;
        op_last  <= k_wrap ? (max_k == '0)
                           : ((op_k + ONE) == max_k);
      end
    end
  end

endmodule

// File: tb/tb_mm_loop_sequencer.sv
// Scoreboard bench for mm_loop_sequencer: a nested-loop model
// queues expected ops and done events, a monitor pops and compares.
module tb_mm_loop_sequencer;

  localparam int W = 4;
  localparam int DMAX = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  cfg_m = 32'd1;
  logic [31:0]  cfg_k = 32'd1;
  logic [31:0]  cfg_n = 32'd1;
  logic         start = 1'b0;
  logic         op_ready = 1'b0;
  logic         dp_idle = 1'b0;
  logic         done;
  logic         busy;
  logic         cfg_err;
  logic         op_valid;
  logic [W-1:0] op_i;
  logic [W-1:0] op_j;
  logic [W-1:0] op_k;
  logic         op_first;
  logic         op_last;

  mm_loop_sequencer #(.IDX_W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_m   (cfg_m),
    .cfg_k   (cfg_k),
    .cfg_n   (cfg_n),
    .start   (start),
    .done    (done),
    .busy    (busy),
    .cfg_err (cfg_err),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_i    (op_i),
    .op_j    (op_j),
    .op_k    (op_k),
    .op_first(op_first),
    .op_last (op_last),
    .dp_idle (dp_idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    int i;
    int j;
    int k;
    bit first;
    bit last;
  } exp_op_t;

  exp_op_t opq[$];
  bit      doneq[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_base = 0;
  int rdy_mode = 0;
  int idle_mode = 1;
  int rdy_ph = 0;

  task automatic check(input string name, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model: the index space walked with plain nested loops
  task automatic expect_run(input int m, input int k, input int n);
    bit ok;
    ok = (m >= 1 && m <= DMAX) && (k >= 1 && k <= DMAX) &&
         (n >= 1 && n <= DMAX);
    if (ok) begin
      for (int i = 0; i < m; i++)
        for (int j = 0; j < n; j++)
          for (int kk = 0; kk < k; kk++)
            opq.push_back('{i, j, kk, kk == 0, kk == k - 1});
    end
    doneq.push_back(!ok);
  endtask

  // monitor
  logic         stall_prev = 1'b0;
  logic [14:0]  held;
  exp_op_t      e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev)
        check("stall_hold",
              {op_valid, op_i, op_j, op_k, op_first, op_last},
              {1'b1, held[13:0]});
      if (op_valid && op_ready) begin
        if (opq.size() == 0) begin
          check("extra_op", 1, 0);
        end else begin
          e = opq.pop_front();
          check("op_i", op_i, e.i);
          check("op_j", op_j, e.j);
          check("op_k", op_k, e.k);
          check("op_first", op_first, e.first);
          check("op_last", op_last, e.last);
        end
      end
      if (done) begin
        done_cnt++;
        if (doneq.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("done_cfg_err", cfg_err, doneq.pop_front());
          check("done_ops_left", opq.size(), 0);
        end
      end
      stall_prev = op_valid && !op_ready;
      held = {op_valid, op_i, op_j, op_k, op_first, op_last};
    end else begin
      stall_prev = 1'b0;
    end
  end

  // handshake partners: ready and dp_idle patterns
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: op_ready = 1'b1;
      1: op_ready = 1'($urandom_range(0, 1));
      default: begin
        op_ready = (rdy_ph % 3 == 0);
        rdy_ph++;
      end
    endcase
    case (idle_mode)
      0: dp_idle = 1'b0;
      1: dp_idle = 1'b1;
      default: dp_idle = ($urandom_range(0, 3) == 0);
    endcase
  end

  task automatic start_run(input int m, input int k, input int n);
    @(posedge clk);
    #1;
    done_base = done_cnt;
    cfg_m = m;
    cfg_k = k;
    cfg_n = n;
    start = 1'b1;
    expect_run(m, k, n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int c;
    c = 0;
    while (done_cnt == done_base && c < bound) begin
      @(posedge clk);
      c++;
    end
    if (done_cnt == done_base) check("done_timeout", 0, 1);
  endtask

  task automatic check_zero(input string name);
    check(name, {done, busy, cfg_err, op_valid, op_i, op_j,
                 op_k, op_first, op_last}, 0);
  endtask

  initial begin
    int m;
    int k;
    int n;
    int c;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_outputs");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 2x2x2, always ready: back-to-back ops
    rdy_mode = 0;
    idle_mode = 1;
    start_run(2, 2, 2);
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      check("no_bubble", {busy, op_valid}, 2'b11);
    end
    wait_done(20);

    // stalls: ready 1,0,0,1,...
    rdy_mode = 2;
    rdy_ph = 0;
    start_run(1, 3, 1);
    wait_done(60);

    // illegal K=0
    rdy_mode = 1;
    start_run(2, 0, 2);
    @(negedge clk);
    check("illegal_done", {done, cfg_err, op_valid}, 3'b110);
    @(negedge clk);
    check("illegal_after", {done, busy, op_valid}, 0);
    wait_done(5);

    // K just above the index range
    start_run(1, DMAX + 1, 1);
    wait_done(10);

    // K at the top of the index range clears cfg_err
    start_run(1, DMAX, 1);
    @(negedge clk);
    check("cfg_err_cleared", cfg_err, 0);
    wait_done(100);

    // start pulse and cfg_m change mid-run are ignored
    rdy_mode = 1;
    idle_mode = 2;
    start_run(2, 2, 2);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    cfg_m = 3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(200);

    // dp_idle held low after the last op
    rdy_mode = 0;
    idle_mode = 0;
    start_run(1, 2, 2);
    c = 0;
    while (opq.size() != 0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("drain_ops_done", opq.size(), 0);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("drain_wait", {busy, done, op_valid}, 3'b100);
    end
    @(posedge clk);
    #1;
    idle_mode = 1;
    dp_idle = 1'b1;
    wait_done(10);
    @(negedge clk);
    check("busy_after_done", {busy, done}, 0);

    // reset in the middle of ISSUE
    rdy_mode = 0;
    start_run(2, 3, 2);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("mid_reset_outputs");
    opq.delete();
    doneq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    c = done_cnt;
    repeat (5) @(negedge clk);
    check("no_done_after_reset", done_cnt, c);
    start_run(1, 2, 1);
    wait_done(20);

    // randomized runs
    rdy_mode = 1;
    idle_mode = 2;
    for (int r = 0; r < 25; r++) begin
      m = $urandom_range(1, 4);
      k = $urandom_range(1, 4);
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 7) == 0) k = 0;
      if ($urandom_range(0, 9) == 0) m = DMAX + 1;
      start_run(m, k, n);
      wait_done(400);
    end

    check("final_ops_left", opq.size(), 0);
    check("final_done_left", doneq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
